// File: rtl/frame_buf_sched.sv
// rtl/frame_buf_sched.sv - N-buffer slot scheduler for frame writer/reader
// Writer never owns the slot being scanned; reader always takes the newest complete frame.
module frame_buf_sched #(
   parameter longint unsigned START_ADDR    = 0,
   parameter int              FRAMES_AMOUNT = 3,
   parameter longint unsigned FRAME_SIZE_B  = 1920*1080*2,
   parameter int              ADDR_WIDTH    = 32,
   parameter int              CNT_WIDTH     = 16,
   localparam int             IDX_WIDTH     = $clog2(FRAMES_AMOUNT)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_done_stb_i,
   input  logic                  rd_done_stb_i,
   input  logic                  clr_cnt_i,
   output logic [IDX_WIDTH-1:0]  wr_idx_o,
   output logic [IDX_WIDTH-1:0]  rd_idx_o,
   output logic [ADDR_WIDTH-1:0] wr_base_addr_o,
   output logic [ADDR_WIDTH-1:0] rd_base_addr_o,
   output logic                  rd_frame_valid_o,
   output logic                  new_frame_o,
   output logic [CNT_WIDTH-1:0]  dropped_cnt_o,
   output logic [CNT_WIDTH-1:0]  repeated_cnt_o
);

   generate
      if (FRAMES_AMOUNT < 3) begin : g_frames_check
         $error("frame_buf_sched: FRAMES_AMOUNT must be >= 3");
      end
   endgenerate

   localparam logic [IDX_WIDTH-1:0]  LAST_IDX    = IDX_WIDTH'(FRAMES_AMOUNT - 1);
   localparam logic [ADDR_WIDTH-1:0] START_A     = ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH-1:0] FRAME_A     = ADDR_WIDTH'(FRAME_SIZE_B);
   localparam logic [ADDR_WIDTH-1:0] RD_RST_ADDR = START_A + ADDR_WIDTH'(LAST_IDX) * FRAME_A;
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;

   logic [IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
   logic [IDX_WIDTH-1:0]  ready_idx_q, ready_idx_d;
   logic                  ready_valid_q, ready_valid_d;
   logic                  rd_frame_valid_q, rd_frame_valid_d;
   logic                  new_frame_q, new_frame_d;
   logic [CNT_WIDTH-1:0]  dropped_cnt_q, dropped_cnt_d;
   logic [CNT_WIDTH-1:0]  repeated_cnt_q, repeated_cnt_d;
   logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
   logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
   logic [IDX_WIDTH-1:0]  rr_next;
   logic                  drop_inc;
   logic                  rep_inc;

   function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] i);
      return (i == LAST_IDX) ? '0 : i + IDX_WIDTH'(1);
   endfunction

   always_comb begin
      wr_idx_d         = wr_idx_q;
      rd_idx_d         = rd_idx_q;
      ready_idx_d      = ready_idx_q;
      ready_valid_d    = ready_valid_q;
      rd_frame_valid_d = rd_frame_valid_q;
      new_frame_d      = 1'b0;
      drop_inc         = 1'b0;
      rep_inc          = 1'b0;

      // Round-robin successor that skips the slot currently being scanned.
      rr_next = next_idx(wr_idx_q);
      if (rr_next == rd_idx_q) begin
         rr_next = next_idx(rr_next);
      end

      case ({wr_done_stb_i, rd_done_stb_i})
         2'b11: begin
            rd_idx_d         = wr_idx_q;
            ready_valid_d    = 1'b0;
            rd_frame_valid_d = 1'b1;
            new_frame_d      = 1'b1;
            if (ready_valid_q) begin
               wr_idx_d = ready_idx_q;
               drop_inc = 1'b1;
            end else begin
               wr_idx_d = rd_idx_q;
            end
         end
         2'b10: begin
            if (ready_valid_q) begin
               wr_idx_d = ready_idx_q;
               drop_inc = 1'b1;
            end else begin
               wr_idx_d = rr_next;
            end
            ready_idx_d   = wr_idx_q;
            ready_valid_d = 1'b1;
         end
         2'b01: begin
            if (ready_valid_q) begin
               rd_idx_d         = ready_idx_q;
               ready_valid_d    = 1'b0;
               rd_frame_valid_d = 1'b1;
               new_frame_d      = 1'b1;
            end else if (rd_frame_valid_q) begin
               rep_inc = 1'b1;
            end
         end
         default: ;
      endcase

      // Clear beats a coincident increment; counters stick at all-ones.
      dropped_cnt_d  = dropped_cnt_q;
      repeated_cnt_d = repeated_cnt_q;
      if (clr_cnt_i) begin
         dropped_cnt_d  = '0;
         repeated_cnt_d = '0;
      end else begin
         if (drop_inc && dropped_cnt_q != CNT_MAX) dropped_cnt_d = dropped_cnt_q + CNT_WIDTH'(1);
         if (rep_inc && repeated_cnt_q != CNT_MAX) repeated_cnt_d = repeated_cnt_q + CNT_WIDTH'(1);
      end

      wr_base_d = START_A + ADDR_WIDTH'(wr_idx_d) * FRAME_A;
      rd_base_d = START_A + ADDR_WIDTH'(rd_idx_d) * FRAME_A;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_idx_q         <= '0;
         rd_idx_q         <= LAST_IDX;
         ready_idx_q      <= '0;
         ready_valid_q    <= 1'b0;
         rd_frame_valid_q <= 1'b0;
         new_frame_q      <= 1'b0;
         dropped_cnt_q    <= '0;
         repeated_cnt_q   <= '0;
         wr_base_q        <= START_A;
         rd_base_q        <= RD_RST_ADDR;
      end else begin
         wr_idx_q         <= wr_idx_d;
         rd_idx_q         <= rd_idx_d;
         ready_idx_q      <= ready_idx_d;
         ready_valid_q    <= ready_valid_d;
         rd_frame_valid_q <= rd_frame_valid_d;
         new_frame_q      <= new_frame_d;
         dropped_cnt_q    <= dropped_cnt_d;
         repeated_cnt_q   <= repeated_cnt_d;
         wr_base_q        <= wr_base_d;
         rd_base_q        <= rd_base_d;
      end
   end

   assign wr_idx_o         = wr_idx_q;
   assign rd_idx_o         = rd_idx_q;
   assign wr_base_addr_o   = wr_base_q;
   assign rd_base_addr_o   = rd_base_q;
   assign rd_frame_valid_o = rd_frame_valid_q;
   assign new_frame_o      = new_frame_q;
   assign dropped_cnt_o    = dropped_cnt_q;
   assign repeated_cnt_o   = repeated_cnt_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb/tb_frame_buf_sched.sv - scoreboard bench for frame_buf_sched (N=3 with 2-bit counters, N=5)
module tb_frame_buf_sched;

   localparam longint FS     = 1920*1080*2;
   localparam longint BASE3  = 64'h8000_0000;
   localparam longint BASE5  = 64'hFFF0_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, wd = 1'b0, rdn = 1'b0, clr = 1'b0;

   logic [1:0]  wr3, rd3, dc3, rc3;
   logic [31:0] wa3, ra3;
   logic        fv3, nf3;
   logic [2:0]  wr5, rd5;
   logic [31:0] wa5, ra5;
   logic        fv5, nf5;
   logic [15:0] dc5, rc5;

   frame_buf_sched #(.START_ADDR(BASE3), .FRAMES_AMOUNT(3), .FRAME_SIZE_B(FS),
                     .ADDR_WIDTH(32), .CNT_WIDTH(2)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .wr_done_stb_i(wd), .rd_done_stb_i(rdn), .clr_cnt_i(clr),
      .wr_idx_o(wr3), .rd_idx_o(rd3), .wr_base_addr_o(wa3), .rd_base_addr_o(ra3),
      .rd_frame_valid_o(fv3), .new_frame_o(nf3), .dropped_cnt_o(dc3), .repeated_cnt_o(rc3));

   frame_buf_sched #(.START_ADDR(BASE5), .FRAMES_AMOUNT(5), .FRAME_SIZE_B(FS),
                     .ADDR_WIDTH(32), .CNT_WIDTH(16)) u_dut5 (
      .clk_i(clk), .rst_i(rst), .wr_done_stb_i(wd), .rd_done_stb_i(rdn), .clr_cnt_i(clr),
      .wr_idx_o(wr5), .rd_idx_o(rd5), .wr_base_addr_o(wa5), .rd_base_addr_o(ra5),
      .rd_frame_valid_o(fv5), .new_frame_o(nf5), .dropped_cnt_o(dc5), .repeated_cnt_o(rc5));

   typedef struct {int wr; int rd; int rdy; bit rv; bit fv; bit nf; int drop; int rep;} model_t;
   typedef struct {int wr; int rd; longint wa; longint ra; bit fv; bit nf; int drop; int rep;} exp_t;

   exp_t   q3[$], q5[$];
   model_t m3, m5;
   int     vectors = 0, miscompares = 0;

   // First slot after the writer's current one, in circular order, that is not being read.
   function automatic int next_free(int wr, int rd, int n);
      for (int k = 1; k < n; k++)
         if ((wr + k) % n != rd) return (wr + k) % n;
      return wr;
   endfunction

   function automatic model_t mstep(model_t m, int n, int cmax, bit r, bit w, bit d, bit c);
      model_t s = m;
      bit drop = 1'b0, rep = 1'b0;
      s.nf = 1'b0;
      if (r) begin
         s.wr = 0; s.rd = n - 1; s.rdy = 0; s.rv = 0; s.fv = 0; s.drop = 0; s.rep = 0;
         return s;
      end
      if (w && d) begin
         s.rd = m.wr; s.rv = 0; s.fv = 1; s.nf = 1;
         s.wr = m.rv ? m.rdy : m.rd;
         drop = m.rv;
      end else if (w) begin
         s.wr = m.rv ? m.rdy : next_free(m.wr, m.rd, n);
         drop = m.rv;
         s.rdy = m.wr; s.rv = 1;
      end else if (d) begin
         if (m.rv) begin
            s.rd = m.rdy; s.rv = 0; s.fv = 1; s.nf = 1;
         end else if (m.fv) begin
            rep = 1'b1;
         end
      end
      if (c) begin
         s.drop = 0; s.rep = 0;
      end else begin
         if (drop) s.drop = (m.drop + 1 > cmax) ? cmax : m.drop + 1;
         if (rep)  s.rep  = (m.rep + 1 > cmax) ? cmax : m.rep + 1;
      end
      return s;
   endfunction

   function automatic exp_t to_exp(model_t m, longint base);
      exp_t e;
      e.wr = m.wr; e.rd = m.rd; e.fv = m.fv; e.nf = m.nf; e.drop = m.drop; e.rep = m.rep;
      e.wa = (base + m.wr * FS) & 64'hFFFF_FFFF;
      e.ra = (base + m.rd * FS) & 64'hFFFF_FFFF;
      return e;
   endfunction

   task automatic cmp(string nm, exp_t e, int wr, int rd, longint wa, longint ra,
                      bit fv, bit nf, int dc, int rc);
      vectors++;
      if (wr != e.wr || rd != e.rd || wa != e.wa || ra != e.ra || fv != e.fv ||
          nf != e.nf || dc != e.drop || rc != e.rep) begin
         miscompares++;
         $display("FAIL %s got wr=%0d rd=%0d wa=%h ra=%h fv=%0d nf=%0d drop=%0d rep=%0d exp wr=%0d rd=%0d wa=%h ra=%h fv=%0d nf=%0d drop=%0d rep=%0d",
                  nm, wr, rd, wa, ra, fv, nf, dc, rc,
                  e.wr, e.rd, e.wa, e.ra, e.fv, e.nf, e.drop, e.rep);
      end
      vectors++;
      if (wr == rd) begin
         miscompares++;
         $display("FAIL %s_invariant wr_idx=%0d equals rd_idx=%0d, required different", nm, wr, rd);
      end
   endtask

   // Monitor: one expected record per clock, popped just after the edge that produced it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q3.size() > 0)
            cmp("n3", q3.pop_front(), int'(wr3), int'(rd3), longint'(wa3), longint'(ra3),
                fv3, nf3, int'(dc3), int'(rc3));
         if (q5.size() > 0)
            cmp("n5", q5.pop_front(), int'(wr5), int'(rd5), longint'(wa5), longint'(ra5),
                fv5, nf5, int'(dc5), int'(rc5));
      end
   end

   task automatic check_const(string nm, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s got %0h required %0h", nm, act, exp);
      end
   endtask

   // Called on a falling edge; returns on the next falling edge with outputs updated.
   task automatic step(bit r, bit w, bit d, bit c);
      rst = r; wd = w; rdn = d; clr = c;
      m3 = mstep(m3, 3, 3, r, w, d, c);
      m5 = mstep(m5, 5, 65535, r, w, d, c);
      q3.push_back(to_exp(m3, BASE3));
      q5.push_back(to_exp(m5, BASE5));
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      step(1, 0, 0, 0);
      check_const("rst_wr", wr3, 0);
      check_const("rst_rd", rd3, 2);
      check_const("rst_fv", fv3, 0);
      check_const("rst_drop", dc3, 0);
      check_const("rst_wa", wa3, 64'h8000_0000);
      check_const("rst_ra", ra3, 64'h807E_9000);

      step(0, 1, 0, 0);
      check_const("wd1_wr", wr3, 1);
      check_const("wd1_wa", wa3, 64'h803F_4800);
      step(0, 0, 1, 0);
      check_const("rd1_rd", rd3, 0);
      check_const("rd1_nf", nf3, 1);
      check_const("rd1_fv", fv3, 1);
      step(0, 0, 0, 0);
      check_const("idle_nf", nf3, 0);
      step(0, 1, 0, 0);
      check_const("wd2_wr", wr3, 2);

      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      check_const("seq_wr_a", wr3, 1);
      step(0, 1, 0, 0);
      check_const("seq_wr_b", wr3, 0);
      step(0, 1, 0, 0);
      check_const("seq_wr_c", wr3, 1);
      check_const("seq_drop", dc3, 2);
      step(0, 0, 1, 0);
      check_const("seq_rd", rd3, 0);
      step(0, 0, 1, 0);
      check_const("rep_rd", rd3, 0);
      check_const("rep_cnt", rc3, 1);
      check_const("rep_nf", nf3, 0);

      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      check_const("early_rd_rep", rc3, 0);
      check_const("early_rd_idx", rd3, 2);

      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      check_const("sim_rd", rd3, 1);
      check_const("sim_wr", wr3, 0);
      check_const("sim_drop", dc3, 1);
      check_const("sim_nf", nf3, 1);

      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      check_const("sat_drop", dc3, 3);
      step(0, 1, 0, 1);
      check_const("clr_drop", dc3, 0);

      for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      step(1, 1, 1, 0);
      check_const("midrst_wr", wr3, 0);
      check_const("midrst_rd", rd3, 2);
      check_const("midrst_fv", fv3, 0);
      check_const("midrst_nf", nf3, 0);
      check_const("midrst_rd5", rd5, 4);

      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 49) == 0);
      end
      step(0, 0, 0, 0);

      for (int i = 0; i < 10 && (q3.size() > 0 || q5.size() > 0); i++) @(negedge clk);
      vectors++;
      if (q3.size() > 0 || q5.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required 0", q3.size() + q5.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
Triple/N-buffer index scheduler for the frame buffer's write and read controllers, in one clock domain. Done strobes from the write path arrive already synchronised into this domain. The block decides which frame slot the writer fills next and which slot the reader scans out. The writer never touches the slot being read, and the reader always gets the newest complete frame. It outputs slot indices, slot base addresses, and drop/repeat statistics.

Parameters:
START_ADDR, 0, byte address of slot 0
FRAMES_AMOUNT, 3, number of frame slots; must be >= 3 (elaboration error otherwise)
FRAME_SIZE_B, 1920*1080*2, bytes per slot
ADDR_WIDTH, 32, width of base-address outputs
CNT_WIDTH, 16, width of statistics counters
(derived) IDX_WIDTH = $clog2(FRAMES_AMOUNT)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
wr_done_stb_i  input  1  one-cycle pulse: writer finished slot wr_idx_o
rd_done_stb_i  input  1  one-cycle pulse: reader finished a frame (frame boundary)
clr_cnt_i  input  1  clear statistics counters
wr_idx_o  output  IDX_WIDTH  slot the writer fills
rd_idx_o  output  IDX_WIDTH  slot the reader scans
wr_base_addr_o  output  ADDR_WIDTH  START_ADDR + wr_idx_o*FRAME_SIZE_B
rd_base_addr_o  output  ADDR_WIDTH  START_ADDR + rd_idx_o*FRAME_SIZE_B
rd_frame_valid_o  output  1  reader holds at least one complete frame
new_frame_o  output  1  one-cycle pulse: rd_idx_o switched to a fresh frame
dropped_cnt_o  output  CNT_WIDTH  completed frames overwritten before being read
repeated_cnt_o  output  CNT_WIDTH  read frames repeated because no new frame was ready

Behaviour:
- One clock (clk_i); reset synchronous, active-high (rst_i).
- Internal state: wr_idx, rd_idx, ready_idx, ready_valid (newest complete, unread slot), rd_frame_valid, counters. All outputs are registered.
- Reset values:
  - wr_idx=0, rd_idx=FRAMES_AMOUNT-1, ready_idx=0, ready_valid=0.
  - rd_frame_valid_o=0, new_frame_o=0, counters=0.
  - Base addresses correspond to the reset indices.
- Latency: all outputs update on the clock edge that samples the strobe. New values are visible in the cycle after the strobe. Base addresses change in the same cycle as their indices.
- Writer next-slot rule (round-robin, used when ready_valid=0): n=(wr_idx+1) mod N; if n==rd_idx then n=(n+1) mod N. N>=3 guarantees a free slot.
- wr_done only:
  - If ready_valid=1: previous ready frame is dropped; dropped_cnt+1; wr_idx<=old ready_idx.
  - Else: wr_idx<=round-robin next.
  - In both cases: ready_idx<=old wr_idx, ready_valid<=1.
- rd_done only:
  - If ready_valid=1: rd_idx<=ready_idx, ready_valid<=0, rd_frame_valid<=1, new_frame_o pulses.
  - Else if rd_frame_valid=1: rd_idx unchanged, repeated_cnt+1.
  - Else: no change, no count.
- wr_done and rd_done in the same cycle (write completes first, reader takes it immediately):
  - rd_idx<=old wr_idx, ready_valid<=0, rd_frame_valid<=1, new_frame_o pulses.
  - wr_idx<=old ready_idx with dropped_cnt+1 if ready_valid was 1; else wr_idx<=old rd_idx.
- Invariant (asserted in bench): wr_idx != rd_idx always. When ready_valid=1, ready_idx differs from both wr_idx and rd_idx.
- Counters saturate at all-ones (no wrap). clr_cnt_i clears both counters next cycle and wins over a simultaneous increment.
- Address arithmetic: multiply by a constant, computed in the same registered stage; result truncated to ADDR_WIDTH.
- rst_i asserted mid-operation returns all state to reset values on that edge. Strobes coincident with reset are ignored.

Test Plan:
- Reset, N=3: wr_idx_o=0, rd_idx_o=2, rd_frame_valid_o=0, counters 0, wr_base_addr_o=START_ADDR.
- wr_done -> wr_idx_o=1, ready=0; then rd_done -> rd_idx_o=0, new_frame_o one-cycle pulse, rd_frame_valid_o=1; then wr_done -> wr_idx_o=2.
- Three wr_done with no rd_done (from reset) -> wr_idx sequence 1,0,1 via recycling; dropped_cnt_o=2. Next rd_done -> rd_idx_o=0 (last completed slot).
- rd_done with nothing ready after first frame -> rd_idx_o unchanged, repeated_cnt_o+1, no new_frame_o. rd_done before any frame -> no count.
- Simultaneous wr_done+rd_done with ready_valid=1 (wr=1, rd=2, ready=0) -> rd_idx_o=1, wr_idx_o=0, dropped_cnt_o+1, new_frame_o pulse.
- CNT_WIDTH=2: four drops -> dropped_cnt_o holds at 3. clr_cnt_i coincident with a drop -> 0. rst_i mid-stream -> reset values. Invariant checked every cycle for 10k random strobes with N=3 and N=5.
